// File: rtl/picosoc_timer.sv
// Memory-mapped down-counting timer for the PicoSoC iomem bus: prescaler,
// one-shot / auto-reload counter, and a level interrupt.
module picosoc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        irq
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic        auto_reload;
    logic        irq_en;
    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic [31:0] count;
    logic [31:0] reload;
    logic        expired;

    logic        sel;
    logic        acc;
    logic        wr;
    logic [2:0]  offs;
    logic        en;
    logic        tick;
    logic        expire;
    logic [31:0] rd_val;
    logic        unused_addr;

    function automatic logic [31:0] byte_merge(input logic [31:0] old,
                                               input logic [31:0] din,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = din[8*b +: 8];
        end
        return r;
    endfunction

    assign sel         = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
    assign acc         = sel && !iomem_ready;
    assign wr          = acc && (iomem_wstrb != 4'b0000);
    assign offs        = iomem_addr[4:2];
    assign unused_addr = ^iomem_addr[1:0];
    assign en          = (state == RUN);
    assign tick        = en && (pre_cnt == 16'd0);
    assign expire      = tick && (count == 32'd0);
    assign irq         = expired && irq_en;

    always_comb begin
        rd_val = 32'd0;
        case (offs)
            3'd0:    rd_val = {29'd0, irq_en, auto_reload, en};
            3'd1:    rd_val = {16'd0, prescale};
            3'd2:    rd_val = count;
            3'd3:    rd_val = reload;
            3'd4:    rd_val = {31'd0, expired};
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= 16'd0;
            pre_cnt     <= 16'd0;
            count       <= 32'd0;
            reload      <= 32'd0;
            expired     <= 1'b0;
            iomem_ready <= 1'b0;
            iomem_rdata <= 32'd0;
        end else begin
            iomem_ready <= acc;
            iomem_rdata <= acc ? rd_val : 32'd0;

            // Prescaler keeps its own running value; PRESCALE writes land at the next reload
            if (!en || pre_cnt == 16'd0) pre_cnt <= prescale;
            else                         pre_cnt <= pre_cnt - 16'd1;

            if (wr && offs == 3'd1) begin
                if (iomem_wstrb[0]) prescale[7:0]  <= iomem_wdata[7:0];
                if (iomem_wstrb[1]) prescale[15:8] <= iomem_wdata[15:8];
            end

            if (wr && offs == 3'd3) reload <= byte_merge(reload, iomem_wdata, iomem_wstrb);

            // A bus write to COUNT takes priority over the tick
            if (wr && offs == 3'd2) begin
                count <= byte_merge(count, iomem_wdata, iomem_wstrb);
            end else if (tick) begin
                if (count != 32'd0)   count <= count - 32'd1;
                else if (auto_reload) count <= reload;
            end

            if (wr && offs == 3'd0 && iomem_wstrb[0]) begin
                state       <= iomem_wdata[0] ? RUN : IDLE;
                auto_reload <= iomem_wdata[1];
                irq_en      <= iomem_wdata[2];
            end else if (expire && !auto_reload) begin
                state <= IDLE;
            end

            // A fresh expiry wins over a simultaneous write-1-to-clear
            if (expire) expired <= 1'b1;
            else if (wr && offs == 3'd4 && iomem_wstrb[0] && iomem_wdata[0]) expired <= 1'b0;
        end
    end

endmodule
